// File: rtl/press_pkg.sv
// Shared types and constants for the push-button value setting path
// and the BCD stepping logic it shares with the timer countdown.
package press_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } press_state_e;

    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
    localparam logic       MODE_INC      = 1'b0;
    localparam logic       MODE_DEC      = 1'b1;

endpackage

// File: rtl/bcd_step.sv
// Combinational single step of a 2-digit BCD value, wrapping 99<->00.
// Out-of-range digits are treated as 9 on increment so the result stays valid BCD.
module bcd_step
    import press_pkg::*;
(
    input  logic [7:0] value,
    input  logic       dir,
    output logic [7:0] value_next
);

    logic [3:0] tens;
    logic [3:0] units;

    assign tens  = value[7:4];
    assign units = value[3:0];

    always_comb begin
        value_next = value;
        if (dir == MODE_DEC) begin
            if (units == 4'd0) begin
                value_next = {((tens == 4'd0) ? BCD_MAX_DIGIT : tens - 4'd1), BCD_MAX_DIGIT};
            end else begin
                value_next = {tens, units - 4'd1};
            end
        end else begin
            if (units >= BCD_MAX_DIGIT) begin
                value_next = {((tens >= BCD_MAX_DIGIT) ? 4'd0 : tens + 4'd1), 4'd0};
            end else begin
                value_next = {tens, units + 4'd1};
            end
        end
    end

endmodule

// File: rtl/press_value_counter.sv
// Turns debounced button pulses into a 2-digit BCD setting value with
// single-step on press and auto-repeat after a long hold.
module press_value_counter
    import press_pkg::*;
#(
    parameter int HOLD_CYCLES   = 100_000_000,
    parameter int REPEAT_CYCLES = 20_000_000,
    parameter int CNT_W         = 27
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       PB_state,
    input  logic       PB_down,
    input  logic       PB_up,
    input  logic       mode,
    input  logic       clr,
    output logic [7:0] Y,
    output logic       short_press,
    output logic       long_press
);

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    press_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             step;
    logic             short_d;
    logic             long_d;
    logic [7:0]       y_stepped;

    bcd_step u_bcd_step (
        .value      (Y),
        .dir        (mode),
        .value_next (y_stepped)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step    = 1'b0;
        short_d = 1'b0;
        long_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // A press coinciding with a release pulse is treated as a glitch.
                if (PB_down && !PB_up) begin
                    step    = 1'b1;
                    cnt_d   = '0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (PB_up) begin
                    short_d = 1'b1;
                    state_d = IDLE;
                end else if (!PB_state) begin
                    state_d = IDLE;
                end else if (cnt_q == HOLD_LAST) begin
                    long_d  = 1'b1;
                    step    = 1'b1;
                    cnt_d   = '0;
                    state_d = REPEAT;
                end
            end
            REPEAT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (PB_up || !PB_state) begin
                    state_d = IDLE;
                end else if (cnt_q == REPEAT_LAST) begin
                    step  = 1'b1;
                    cnt_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            Y           <= 8'h00;
            short_press <= 1'b0;
            long_press  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            short_press <= short_d;
            long_press  <= long_d;
            // Clear overrides a step due in the same cycle but leaves the FSM alone.
            if (clr) begin
                Y <= 8'h00;
            end else if (step) begin
                Y <= y_stepped;
            end
        end
    end

endmodule
